// File: rtl/sdram_port_arbiter.sv
// Three-port burst arbiter (p3 > p2 > p1) feeding 4-word bursts to the SDRAM controller.
// Define SDRAM_ARB_ROUND_ROBIN_EN to alternate p1/p2 fairly while p3 keeps top priority.
module sdram_port_arbiter #(
  parameter int                ADDR_W  = 24,
  parameter logic [ADDR_W-1:0] P3_BASE = 24'hFE0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p1_req,
  input  logic [31:0]       p1_address,
  output logic              p1_ready,
  output logic [1:0]        p1_offset,
  input  logic              p2_req,
  input  logic              p2_wren,
  input  logic [31:0]       p2_address,
  input  logic [15:0]       p2_to_mem,
  output logic              p2_ready,
  output logic [1:0]        p2_offset,
  input  logic              p3_req,
  input  logic              p3_wren,
  input  logic [16:0]       p3_address,
  input  logic [15:0]       p3_to_mem,
  output logic              p3_ready,
  output logic [1:0]        p3_offset,
  output logic [15:0]       from_mem,
  output logic              ctrl_req,
  output logic              ctrl_wren,
  output logic [ADDR_W-1:0] ctrl_address,
  output logic [15:0]       ctrl_wdata,
  input  logic              ctrl_ack,
  input  logic              ctrl_rd_valid,
  input  logic              ctrl_wr_next,
  input  logic [15:0]       ctrl_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;
  typedef enum logic [1:0] {G_NONE, G_P1, G_P2, G_P3} grant_t;

  state_t              state_q, state_d;
  grant_t              grant_q, grant_sel;
  logic                wren_q, sel_wren;
  logic [ADDR_W-1:0]   addr_q, sel_addr;
  logic [1:0]          word_cnt_q;
  logic                strobe;
  logic [ADDR_W-1:0]   burst_mask;

  assign burst_mask = {{(ADDR_W-2){1'b1}}, 2'b00};

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // Set when p2 won the most recent p1/p2 decision; cleared state favours p2 next.
  logic last_p2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_p2_q <= 1'b0;
    else if (state_q == S_IDLE && grant_sel == G_P2)
      last_p2_q <= 1'b1;
    else if (state_q == S_IDLE && grant_sel == G_P1)
      last_p2_q <= 1'b0;
  end
`endif

  always_comb begin
    grant_sel = G_NONE;
    if (p3_req)
      grant_sel = G_P3;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    else if (p1_req && p2_req)
      grant_sel = last_p2_q ? G_P1 : G_P2;
`endif
    else if (p2_req)
      grant_sel = G_P2;
    else if (p1_req)
      grant_sel = G_P1;
  end

  // p3 lives in a window above P3_BASE and wraps at the top of the address space.
  always_comb begin
    sel_addr = '0;
    sel_wren = 1'b0;
    case (grant_sel)
      G_P1: sel_addr = {p1_address[ADDR_W-1:2], 2'b00};
      G_P2: begin
        sel_addr = {p2_address[ADDR_W-1:2], 2'b00};
        sel_wren = p2_wren;
      end
      G_P3: begin
        sel_addr = (P3_BASE + {{(ADDR_W-17){1'b0}}, p3_address}) & burst_mask;
        sel_wren = p3_wren;
      end
      default: ;
    endcase
  end

  assign strobe = (state_q == S_XFER) && (wren_q ? ctrl_wr_next : ctrl_rd_valid);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_sel != G_NONE) state_d = S_ISSUE;
      S_ISSUE: if (ctrl_ack) state_d = S_XFER;
      S_XFER:  if (strobe && word_cnt_q == 2'd3) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= G_NONE;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      word_cnt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && grant_sel != G_NONE) begin
        grant_q    <= grant_sel;
        addr_q     <= sel_addr;
        wren_q     <= sel_wren;
        word_cnt_q <= 2'd0;
      end else if (strobe) begin
        word_cnt_q <= word_cnt_q + 2'd1;
      end else if (state_q == S_DONE) begin
        grant_q <= G_NONE;
        wren_q  <= 1'b0;
      end
    end
  end

  assign ctrl_req     = (state_q == S_ISSUE);
  assign ctrl_wren    = wren_q;
  assign ctrl_address = addr_q;
  assign from_mem     = ctrl_rdata;

  always_comb begin
    ctrl_wdata = 16'h0000;
    case (grant_q)
      G_P2:    ctrl_wdata = p2_to_mem;
      G_P3:    ctrl_wdata = p3_to_mem;
      default: ;
    endcase
  end

  assign p1_ready  = strobe && (grant_q == G_P1);
  assign p2_ready  = strobe && (grant_q == G_P2);
  assign p3_ready  = strobe && (grant_q == G_P3);
  assign p1_offset = (grant_q == G_P1) ? word_cnt_q : 2'd0;
  assign p2_offset = (grant_q == G_P2) ? word_cnt_q : 2'd0;
  assign p3_offset = (grant_q == G_P3) ? word_cnt_q : 2'd0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{p1_address[31:ADDR_W], p1_address[1:0],
                              p2_address[31:ADDR_W], p2_address[1:0]};

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter; the bench plays the SDRAM controller.
// A second instance with P3_BASE=24'hFFFFF0 checks p3 address wrap.
module tb_sdram_port_arbiter;

  logic        clk, rst;
  logic        p1_req, p2_req, p2_wren, p3_req, p3_wren;
  logic [31:0] p1_address, p2_address;
  logic [16:0] p3_address;
  logic [15:0] p2_to_mem, p3_to_mem, ctrl_rdata;
  logic        ctrl_ack, ctrl_rd_valid, ctrl_wr_next;
  logic        p1_ready, p2_ready, p3_ready;
  logic [1:0]  p1_offset, p2_offset, p3_offset;
  logic [15:0] from_mem, ctrl_wdata;
  logic        ctrl_req, ctrl_wren;
  logic [23:0] ctrl_address;

  logic        w_p1_ready, w_p2_ready, w_p3_ready;
  logic [1:0]  w_p1_offset, w_p2_offset, w_p3_offset;
  logic [15:0] w_from_mem, w_ctrl_wdata;
  logic        w_ctrl_req, w_ctrl_wren;
  logic [23:0] w_ctrl_address;

  int n_cmp = 0;
  int n_err = 0;

  sdram_port_arbiter u_dut (
    .clk(clk), .rst(rst),
    .p1_req(p1_req), .p1_address(p1_address), .p1_ready(p1_ready), .p1_offset(p1_offset),
    .p2_req(p2_req), .p2_wren(p2_wren), .p2_address(p2_address), .p2_to_mem(p2_to_mem),
    .p2_ready(p2_ready), .p2_offset(p2_offset),
    .p3_req(p3_req), .p3_wren(p3_wren), .p3_address(p3_address), .p3_to_mem(p3_to_mem),
    .p3_ready(p3_ready), .p3_offset(p3_offset),
    .from_mem(from_mem), .ctrl_req(ctrl_req), .ctrl_wren(ctrl_wren),
    .ctrl_address(ctrl_address), .ctrl_wdata(ctrl_wdata), .ctrl_ack(ctrl_ack),
    .ctrl_rd_valid(ctrl_rd_valid), .ctrl_wr_next(ctrl_wr_next), .ctrl_rdata(ctrl_rdata)
  );

  sdram_port_arbiter #(.ADDR_W(24), .P3_BASE(24'hFFFFF0)) u_wrap (
    .clk(clk), .rst(rst),
    .p1_req(p1_req), .p1_address(p1_address), .p1_ready(w_p1_ready), .p1_offset(w_p1_offset),
    .p2_req(p2_req), .p2_wren(p2_wren), .p2_address(p2_address), .p2_to_mem(p2_to_mem),
    .p2_ready(w_p2_ready), .p2_offset(w_p2_offset),
    .p3_req(p3_req), .p3_wren(p3_wren), .p3_address(p3_address), .p3_to_mem(p3_to_mem),
    .p3_ready(w_p3_ready), .p3_offset(w_p3_offset),
    .from_mem(w_from_mem), .ctrl_req(w_ctrl_req), .ctrl_wren(w_ctrl_wren),
    .ctrl_address(w_ctrl_address), .ctrl_wdata(w_ctrl_wdata), .ctrl_ack(ctrl_ack),
    .ctrl_rd_valid(ctrl_rd_valid), .ctrl_wr_next(ctrl_wr_next), .ctrl_rdata(ctrl_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    ctrl_rdata = 16'hBEEF;
    @(negedge clk); #1;
    n_cmp++;
    if ({ctrl_req, ctrl_wren, ctrl_address, ctrl_wdata, p1_ready, p2_ready, p3_ready,
         p1_offset, p2_offset, p3_offset} !== 51'd0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got req=%b wren=%b addr=%h wdata=%h, required all 0",
               ctrl_req, ctrl_wren, ctrl_address, ctrl_wdata);
    end
    n_cmp++;
    if (from_mem !== 16'hBEEF) begin n_err++; $display("[TB] FAIL reset_from_mem: got %h required beef", from_mem); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_p1_read();
    @(negedge clk);
    p1_req = 1'b1; p1_address = 32'h0000_1237;
    @(negedge clk);
    ctrl_rd_valid = 1'b1; #1;
    n_cmp++; if (ctrl_req !== 1'b1) begin n_err++; $display("[TB] FAIL p1_issue_req: got %b required 1", ctrl_req); end
    n_cmp++; if (ctrl_address !== 24'h001234) begin n_err++; $display("[TB] FAIL p1_address: got %h required 001234", ctrl_address); end
    n_cmp++; if (ctrl_wren !== 1'b0) begin n_err++; $display("[TB] FAIL p1_wren: got %b required 0", ctrl_wren); end
    n_cmp++; if (p1_ready !== 1'b0) begin n_err++; $display("[TB] FAIL p1_issue_strobe: got %b required 0", p1_ready); end
    @(negedge clk);
    ctrl_rd_valid = 1'b0; ctrl_ack = 1'b1; #1;
    n_cmp++; if (ctrl_req !== 1'b1) begin n_err++; $display("[TB] FAIL p1_req_held: got %b required 1", ctrl_req); end
    @(negedge clk);
    ctrl_ack = 1'b0; ctrl_wr_next = 1'b1; #1;
    n_cmp++; if (p1_ready !== 1'b0) begin n_err++; $display("[TB] FAIL p1_wr_next_ignored: got %b required 0", p1_ready); end
    n_cmp++; if (ctrl_req !== 1'b0) begin n_err++; $display("[TB] FAIL p1_req_dropped: got %b required 0", ctrl_req); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ctrl_wr_next = 1'b0; ctrl_rd_valid = 1'b1; ctrl_rdata = 16'h00A0 + 16'(i); #1;
      n_cmp++; if (p1_ready !== 1'b1) begin n_err++; $display("[TB] FAIL p1_ready[%0d]: got %b required 1", i, p1_ready); end
      n_cmp++; if (p1_offset !== 2'(i)) begin n_err++; $display("[TB] FAIL p1_offset[%0d]: got %0d required %0d", i, p1_offset, i); end
      n_cmp++; if (from_mem !== 16'h00A0 + 16'(i)) begin n_err++; $display("[TB] FAIL p1_from_mem[%0d]: got %h required %h", i, from_mem, 16'h00A0 + 16'(i)); end
      n_cmp++; if (p2_ready !== 1'b0) begin n_err++; $display("[TB] FAIL p1_p2_ready[%0d]: got %b required 0", i, p2_ready); end
    end
    @(negedge clk);
    p1_req = 1'b0; #1;
    n_cmp++; if (p1_ready !== 1'b0) begin n_err++; $display("[TB] FAIL p1_done_strobe: got %b required 0", p1_ready); end
    @(negedge clk);
    ctrl_rd_valid = 1'b0; #1;
    n_cmp++; if (ctrl_req !== 1'b0) begin n_err++; $display("[TB] FAIL p1_idle_req: got %b required 0", ctrl_req); end
  endtask

  task automatic test_p2_write();
    logic [15:0] tbl [4];
    tbl = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    @(negedge clk);
    p2_req = 1'b1; p2_wren = 1'b1; p2_address = 32'h0000_0040;
    @(negedge clk);
    ctrl_ack = 1'b1; #1;
    n_cmp++; if (ctrl_req !== 1'b1) begin n_err++; $display("[TB] FAIL p2_issue_req: got %b required 1", ctrl_req); end
    n_cmp++; if (ctrl_wren !== 1'b1) begin n_err++; $display("[TB] FAIL p2_wren: got %b required 1", ctrl_wren); end
    n_cmp++; if (ctrl_address !== 24'h000040) begin n_err++; $display("[TB] FAIL p2_address: got %h required 000040", ctrl_address); end
    @(negedge clk);
    ctrl_ack = 1'b0; ctrl_rd_valid = 1'b1; p2_to_mem = tbl[0]; #1;
    n_cmp++; if (p2_ready !== 1'b0) begin n_err++; $display("[TB] FAIL p2_rd_valid_ignored: got %b required 0", p2_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ctrl_rd_valid = 1'b0; ctrl_wr_next = 1'b1; p2_to_mem = tbl[i]; #1;
      n_cmp++; if (p2_ready !== 1'b1) begin n_err++; $display("[TB] FAIL p2_ready[%0d]: got %b required 1", i, p2_ready); end
      n_cmp++; if (p2_offset !== 2'(i)) begin n_err++; $display("[TB] FAIL p2_offset[%0d]: got %0d required %0d", i, p2_offset, i); end
      n_cmp++; if (ctrl_wdata !== tbl[i]) begin n_err++; $display("[TB] FAIL p2_wdata[%0d]: got %h required %h", i, ctrl_wdata, tbl[i]); end
    end
    @(negedge clk);
    ctrl_wr_next = 1'b0; p2_req = 1'b0; p2_wren = 1'b0; #1;
    n_cmp++; if (p2_ready !== 1'b0) begin n_err++; $display("[TB] FAIL p2_done_ready: got %b required 0", p2_ready); end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    int exp_order [7];
    int rem [4];
    int g;
    logic [23:0] exp_addr;
    logic [1:0]  off;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    exp_order = '{3, 2, 1, 2, 1, 2, 1};
`else
    exp_order = '{3, 2, 2, 2, 1, 1, 1};
`endif
    rem = '{0, 3, 3, 1};
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    p1_address = 32'h0000_0100; p2_address = 32'h0000_0200; p3_address = 17'h00010;
    p2_wren = 1'b0; p3_wren = 1'b0;
    p1_req = 1'b1; p2_req = 1'b1; p3_req = 1'b1;
    for (int b = 0; b < 7; b++) begin
      g = exp_order[b];
      exp_addr = (g == 3) ? 24'hFE0010 : (g == 2) ? 24'h000200 : 24'h000100;
      @(negedge clk);
      ctrl_ack = 1'b1; #1;
      n_cmp++; if (ctrl_req !== 1'b1) begin n_err++; $display("[TB] FAIL arb_req[%0d]: got %b required 1", b, ctrl_req); end
      n_cmp++; if (ctrl_address !== exp_addr) begin n_err++; $display("[TB] FAIL arb_grant[%0d]: got addr %h required %h", b, ctrl_address, exp_addr); end
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        ctrl_ack = 1'b0; ctrl_rd_valid = 1'b1; #1;
        off = (g == 3) ? p3_offset : (g == 2) ? p2_offset : p1_offset;
        n_cmp++;
        if ({p3_ready, p2_ready, p1_ready} !== (3'b001 << (g - 1))) begin
          n_err++;
          $display("[TB] FAIL arb_ready[%0d.%0d]: got %b required %b", b, i,
                   {p3_ready, p2_ready, p1_ready}, 3'b001 << (g - 1));
        end
        n_cmp++; if (off !== 2'(i)) begin n_err++; $display("[TB] FAIL arb_offset[%0d.%0d]: got %0d required %0d", b, i, off, i); end
      end
      @(negedge clk);
      ctrl_rd_valid = 1'b0;
      rem[g] = rem[g] - 1;
      if (rem[g] == 0) begin
        if (g == 1) p1_req = 1'b0;
        if (g == 2) p2_req = 1'b0;
        if (g == 3) p3_req = 1'b0;
      end
      #1;
      n_cmp++; if (ctrl_req !== 1'b0) begin n_err++; $display("[TB] FAIL arb_done_req[%0d]: got %b required 0", b, ctrl_req); end
      @(negedge clk); #1;
      n_cmp++; if (ctrl_req !== 1'b0) begin n_err++; $display("[TB] FAIL arb_idle_req[%0d]: got %b required 0", b, ctrl_req); end
    end
  endtask

  task automatic test_drop_mid();
    @(negedge clk);
    p2_req = 1'b1; p2_wren = 1'b0; p2_address = 32'h0000_0080;
    @(negedge clk);
    ctrl_ack = 1'b1; #1;
    n_cmp++; if (ctrl_address !== 24'h000080) begin n_err++; $display("[TB] FAIL drop_address: got %h required 000080", ctrl_address); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ctrl_ack = 1'b0; ctrl_rd_valid = 1'b1;
      if (i == 2) p2_req = 1'b0;
      #1;
      n_cmp++; if (p2_ready !== 1'b1) begin n_err++; $display("[TB] FAIL drop_ready[%0d]: got %b required 1", i, p2_ready); end
      n_cmp++; if (p2_offset !== 2'(i)) begin n_err++; $display("[TB] FAIL drop_offset[%0d]: got %0d required %0d", i, p2_offset, i); end
    end
    @(negedge clk); #1;
    n_cmp++; if (p2_ready !== 1'b0) begin n_err++; $display("[TB] FAIL drop_done_ready: got %b required 0", p2_ready); end
    @(negedge clk);
    ctrl_rd_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (ctrl_req !== 1'b0) begin n_err++; $display("[TB] FAIL drop_no_reissue: got %b required 0", ctrl_req); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    p1_req = 1'b1; p1_address = 32'h0000_0300;
    @(negedge clk);
    ctrl_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ctrl_ack = 1'b0; ctrl_rd_valid = 1'b1;
    end
    @(negedge clk);
    ctrl_rd_valid = 1'b0; rst = 1'b1; ctrl_rdata = 16'h5A5A; #1;
    n_cmp++;
    if ({ctrl_req, ctrl_wren, ctrl_address, ctrl_wdata, p1_ready, p2_ready, p3_ready,
         p1_offset, p2_offset, p3_offset} !== 51'd0) begin
      n_err++;
      $display("[TB] FAIL midreset_outputs: got addr=%h p1_offset=%0d, required all 0", ctrl_address, p1_offset);
    end
    n_cmp++; if (from_mem !== 16'h5A5A) begin n_err++; $display("[TB] FAIL midreset_from_mem: got %h required 5a5a", from_mem); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ctrl_ack = 1'b1; #1;
    n_cmp++; if (ctrl_req !== 1'b1) begin n_err++; $display("[TB] FAIL midreset_reissue: got %b required 1", ctrl_req); end
    n_cmp++; if (ctrl_address !== 24'h000300) begin n_err++; $display("[TB] FAIL midreset_address: got %h required 000300", ctrl_address); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ctrl_ack = 1'b0; ctrl_rd_valid = 1'b1; #1;
      n_cmp++; if (p1_ready !== 1'b1) begin n_err++; $display("[TB] FAIL midreset_ready[%0d]: got %b required 1", i, p1_ready); end
      n_cmp++; if (p1_offset !== 2'(i)) begin n_err++; $display("[TB] FAIL midreset_offset[%0d]: got %0d required %0d", i, p1_offset, i); end
    end
    @(negedge clk);
    ctrl_rd_valid = 1'b0; p1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_p3_wrap();
    logic [15:0] tbl [4];
    tbl = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
    @(negedge clk);
    p3_req = 1'b1; p3_wren = 1'b1; p3_address = 17'h1FFFF;
    @(negedge clk);
    ctrl_ack = 1'b1; #1;
    n_cmp++; if (ctrl_address !== 24'hFFFFFC) begin n_err++; $display("[TB] FAIL p3_address: got %h required fffffc", ctrl_address); end
    n_cmp++; if (w_ctrl_address !== 24'h01FFEC) begin n_err++; $display("[TB] FAIL p3_wrap_address: got %h required 01ffec", w_ctrl_address); end
    n_cmp++; if (ctrl_wren !== 1'b1) begin n_err++; $display("[TB] FAIL p3_wren: got %b required 1", ctrl_wren); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ctrl_ack = 1'b0; ctrl_wr_next = 1'b1; p3_to_mem = tbl[i]; #1;
      n_cmp++; if (p3_ready !== 1'b1) begin n_err++; $display("[TB] FAIL p3_ready[%0d]: got %b required 1", i, p3_ready); end
      n_cmp++; if (p3_offset !== 2'(i)) begin n_err++; $display("[TB] FAIL p3_offset[%0d]: got %0d required %0d", i, p3_offset, i); end
      n_cmp++; if (ctrl_wdata !== tbl[i]) begin n_err++; $display("[TB] FAIL p3_wdata[%0d]: got %h required %h", i, ctrl_wdata, tbl[i]); end
    end
    @(negedge clk);
    ctrl_wr_next = 1'b0; p3_req = 1'b0; p3_wren = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    p1_req = 1'b0; p2_req = 1'b0; p2_wren = 1'b0; p3_req = 1'b0; p3_wren = 1'b0;
    p1_address = '0; p2_address = '0; p3_address = '0;
    p2_to_mem = '0; p3_to_mem = '0; ctrl_rdata = '0;
    ctrl_ack = 1'b0; ctrl_rd_valid = 1'b0; ctrl_wr_next = 1'b0;
    test_reset();
    test_p1_read();
    test_p2_write();
    test_arbitration();
    test_drop_mid();
    test_reset_mid();
    test_p3_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
